issue_arbiter: RTL

Parametrised multi-issue scheduler in the Execute stage, sitting between the reservation stations and the functional units. Each cycle it:
- examines `NUM_RS` reservation-station entries;
- classifies each ready entry by `ALU_op` into a functional-unit class;
- grants up to one entry to every ready unit, issuing several instructions per cycle;
- uses a per-class round-robin pointer for fairness.

Grants are reported combinationally to the stations. The issued operations are registered for one cycle before reaching the units, and can be killed by a flush.

---
 rtl/issue_arbiter.sv | 111 +++++++++++
 1 files changed

// File: rtl/issue_arbiter.sv
// issue_arbiter: per-class round-robin multi-issue scheduler with a one-cycle issue register
package issue_pkg;
    typedef enum logic [3:0] {
        ADD, SUB, AND, OR, XOR, SLT, SLTU, LUI,
        SLL, SRL, SRA, MUL, MULH, DIV, REMU, NOP
    } alu_op_t;
    typedef enum logic [1:0] {NB, BEQ, BNE, JMP} branch_t;
    typedef struct packed {
        logic        valid_operands;
        alu_op_t     ALU_op;
        logic [3:0]  ROB_entry;
        branch_t     branch_type;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic        load;
    } rs_out_t;
    localparam rs_out_t RS_ZERO = '{valid_operands: 1'b0, ALU_op: NOP, ROB_entry: 4'd0,
                                    branch_type: NB, rs1: 32'd0, rs2: 32'd0, load: 1'b0};
endpackage

module issue_arbiter
    import issue_pkg::*;
#(
    parameter int NUM_RS  = 4,
    parameter int NUM_ALU = 2,
    parameter int NUM_MUL = 1,
    parameter int NUM_DIV = 1,
    parameter int NUM_SHF = 1,
    parameter int NUM_FU  = NUM_ALU + NUM_MUL + NUM_DIV + NUM_SHF
) (
    input  logic              clk,
    input  logic              reset,
    input  rs_out_t           rs_data [NUM_RS],
    input  logic [NUM_FU-1:0] ready_bus,
    input  logic              flush,
    output logic [NUM_RS-1:0] consumed_bus,
    output logic [NUM_FU-1:0] fu_valid,
    output rs_out_t           fu_data [NUM_FU]
);
    localparam int PW = (NUM_RS > 1) ? $clog2(NUM_RS) : 1;

    logic [PW-1:0]     r_ptr [4];
    logic [NUM_FU-1:0] r_fu_valid;
    rs_out_t           r_fu_data [NUM_FU];
    logic [PW-1:0]     w_ptr_nxt [4];
    logic [PW-1:0]     w_src [NUM_FU];
    logic [NUM_FU-1:0] w_gnt;
    logic [NUM_RS-1:0] w_consumed;
    logic [PW-1:0]     w_idx;
    logic              w_hit;

    // Class codes: 0 ALU, 1 MUL, 2 DIV, 3 SHF, 4 NONE (never issued)
    function automatic logic [2:0] op_class(alu_op_t op);
        return (op == MUL || op == MULH) ? 3'd1 :
               (op == DIV || op == REMU) ? 3'd2 :
               (op == SRL || op == SRA || op == SLL) ? 3'd3 :
               !op[3] ? 3'd0 : 3'd4;
    endfunction

    function automatic logic [2:0] fu_class(int k);
        return (k < NUM_ALU) ? 3'd0 :
               (k < NUM_ALU + NUM_MUL) ? 3'd1 :
               (k < NUM_ALU + NUM_MUL + NUM_DIV) ? 3'd2 : 3'd3;
    endfunction

    // Walk requesters in rotation order per class, handing each the lowest free ready FU of its class
    always_comb begin
        w_consumed = '0;
        w_gnt      = '0;
        w_src      = '{default: '0};
        w_ptr_nxt  = r_ptr;
        w_idx      = '0;
        w_hit      = 1'b0;
        for (int c = 0; c < 4; c++) begin
            for (int j = 0; j < NUM_RS; j++) begin
                w_idx = PW'((32'(r_ptr[c]) + 32'(j)) % NUM_RS);
                w_hit = 1'b0;
                if (!reset && !flush && rs_data[w_idx].valid_operands &&
                    op_class(rs_data[w_idx].ALU_op) == 3'(c)) begin
                    for (int k = 0; k < NUM_FU; k++) begin
                        if (!w_hit && fu_class(k) == 3'(c) && ready_bus[k] && !w_gnt[k]) begin
                            w_hit             = 1'b1;
                            w_gnt[k]          = 1'b1;
                            w_src[k]          = w_idx;
                            w_consumed[w_idx] = 1'b1;
                            w_ptr_nxt[c]      = PW'((32'(w_idx) + 32'd1) % NUM_RS);
                        end
                    end
                end
            end
        end
    end

    // Advance pointers and capture granted ops; ungranted FUs load a zeroed NOP
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr      <= '{default: '0};
            r_fu_valid <= '0;
            r_fu_data  <= '{default: RS_ZERO};
        end else begin
            r_ptr      <= w_ptr_nxt;
            r_fu_valid <= w_gnt;
            for (int k = 0; k < NUM_FU; k++)
                r_fu_data[k] <= w_gnt[k] ? rs_data[w_src[k]] : RS_ZERO;
        end
    end

    assign consumed_bus = w_consumed;
    assign fu_valid     = r_fu_valid;
    assign fu_data      = r_fu_data;
endmodule
